// File: rtl/oufbuf_rd_streamer_pkg.sv
// Shared definitions for the output-frame read streamer.
// Holds the FSM encoding, default frame geometry, sideband bit layout
// and the RGB565 -> RGB888 expansion helper.
package oufbuf_rd_streamer_pkg;

  localparam int H_PIXELS    = 480;
  localparam int V_LINES     = 272;
  localparam int FRAME_WORDS = H_PIXELS * V_LINES;
  localparam int ADDR_W      = 17;
  localparam int DATA_W      = 16;

  // Sideband travels with each word through the FIFO as {sof, eol, eof}.
  localparam int SB_W   = 3;
  localparam int SB_SOF = 2;
  localparam int SB_EOL = 1;
  localparam int SB_EOF = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // MSB replication keeps full-scale white at 8'hFF and black at 8'h00.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

endpackage

// File: rtl/oufbuf_rd_fifo2.sv
// Purpose : 2-entry first-word-fall-through FIFO holding pixel + sideband.
// Latency : a push is visible at head the cycle after it is written.
// Backpr. : pop only when non-empty; a push while full is taken only with a same-cycle pop.
// Ports   : clk/rst, push/push_data in, pop in, head/count/empty/full out.
module oufbuf_rd_fifo2 #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 2'd1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/oufbuf_rd_streamer.sv
// Purpose : scans one finished RGB565 frame out of SRAM in raster order as a
//           valid/ready pixel stream with sof/eol/eof markers.
// Latency : first oPixValid 3 cycles after iStart; 1 pixel/clock with ready held high.
// Backpr. : reads are credit-limited to the 2-entry FIFO, so stalls never drop or repeat pixels.
// Ports   : iStart/oBusy/oFrameDone control, oRdEn/oRdAddr/iRdData SRAM read port,
//           oPixValid/iPixReady/oPixData/oSof/oEol/oEof stream.
// Option  : define OUFRD_RGB888_EN for 24-bit RGB888 oPixData (expanded from the FIFO head).
module oufbuf_rd_streamer #(
  parameter int H_PIXELS = oufbuf_rd_streamer_pkg::H_PIXELS,
  parameter int V_LINES  = oufbuf_rd_streamer_pkg::V_LINES,
  parameter int ADDR_W   = oufbuf_rd_streamer_pkg::ADDR_W,
  parameter int DATA_W   = oufbuf_rd_streamer_pkg::DATA_W
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  output logic              oBusy,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic [DATA_W-1:0] iRdData,
  output logic              oPixValid,
  input  logic              iPixReady,
`ifdef OUFRD_RGB888_EN
  output logic [23:0]       oPixData,
`else
  output logic [DATA_W-1:0] oPixData,
`endif
  output logic              oSof,
  output logic              oEol,
  output logic              oEof,
  output logic              oFrameDone
);

  import oufbuf_rd_streamer_pkg::*;

  localparam int FRAME_WORDS = H_PIXELS * V_LINES;
  localparam int COL_W       = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int ROW_W       = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int FIFO_W      = DATA_W + SB_W;

  rd_state_t         state_q;
  rd_state_t         state_d;
  logic              busy_q;
  logic              inflight_q;
  logic [SB_W-1:0]   sb_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;

  logic              rd_en;
  logic              frame_done;
  logic              last_addr;
  logic              col_last;
  logic              row_last;
  logic [SB_W-1:0]   sb_issue;
  logic [2:0]        credit_used;

  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [1:0]        fifo_count;
  logic [FIFO_W-1:0] fifo_head;
  logic [DATA_W-1:0] head_data;

  assign fifo_pop = ~fifo_empty & iPixReady;

  // Slots already spoken for: words held (minus the one leaving this cycle)
  // plus the word still coming back from SRAM. A new read needs a free slot.
  assign credit_used = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, inflight_q};

  assign last_addr = (addr_q == ADDR_W'(FRAME_WORDS - 1));
  assign col_last  = (col_q == COL_W'(H_PIXELS - 1));
  assign row_last  = (row_q == ROW_W'(V_LINES - 1));

  always_comb begin
    sb_issue         = '0;
    sb_issue[SB_SOF] = (col_q == '0) && (row_q == '0);
    sb_issue[SB_EOL] = col_last;
    sb_issue[SB_EOF] = col_last && row_last;
  end

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iStart) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en = (credit_used < 3'd2);
        if (rd_en && last_addr) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !inflight_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
      sb_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;

      if (state_q == ST_IDLE && iStart) begin
        busy_q <= 1'b1;
      end else if (fifo_pop && fifo_head[SB_EOF]) begin
        busy_q <= 1'b0;
      end

      if (rd_en) begin
        // Markers are computed at issue and delayed one cycle to meet the SRAM data.
        sb_q   <= sb_issue;
        addr_q <= last_addr ? '0 : addr_q + 1'b1;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  oufbuf_rd_fifo2 #(
    .W (FIFO_W)
  ) u_fifo (
    .clk       (iClk),
    .rst       (iRst),
    .push      (inflight_q),
    .push_data ({iRdData, sb_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_data = fifo_head[FIFO_W-1:SB_W];

  assign oBusy      = busy_q;
  assign oRdEn      = rd_en;
  assign oRdAddr    = addr_q;
  assign oFrameDone = frame_done;
  assign oPixValid  = ~fifo_empty;
  // Markers are gated so they never assert on a stale head entry.
  assign oSof       = ~fifo_empty & fifo_head[SB_SOF];
  assign oEol       = ~fifo_empty & fifo_head[SB_EOL];
  assign oEof       = ~fifo_empty & fifo_head[SB_EOF];

`ifdef OUFRD_RGB888_EN
  assign oPixData = rgb565_to_rgb888(head_data[15:0]);
`else
  assign oPixData = head_data;
`endif

endmodule
